sr_ff_driver: RTL

SR_FF_DRIVER -- requirements
Module: sr_ff_driver

---
 rtl/sr_ff_driver.sv | 191 +++++++++++++++++++
 1 files changed

// File: rtl/sr_ff_driver.sv
// -----------------------------------------------------------------------------
// sr_ff_driver
//
// Writes single bits of an external bank of SR flip-flops and confirms each
// write through the Q readback. A request names one flip-flop and the value it
// should hold. If the readback already shows that value, nothing is driven.
// Otherwise the driver pulses S (to set) or R (to clear) for one cycle, checks
// the readback, and re-drives up to MAX_RETRY more times before it gives up.
// The outcome is reported as a one-cycle DONE or ERR pulse, together with the
// number of re-drives that were used.
//
// Ports
//   CLK        sole clock, rising edge
//   RST        synchronous, active-high reset
//   REQ_VALID  a write request is present
//   REQ_READY  driver is idle and can accept a request
//   REQ_IDX    index of the target flip-flop
//   REQ_VAL    value the target flip-flop should hold
//   S, R       registered set / reset excitation to the bank (all-zero = hold)
//   Q_FB       Q readback from the bank
//   DONE       one-cycle pulse: target bit verified
//   ERR        one-cycle pulse: bad index, or re-drives exhausted
//   RETRIES    re-drives used by the last completed request, held until the
//              next completion
// -----------------------------------------------------------------------------
module sr_ff_driver #(
    parameter int WIDTH     = 8,   // flip-flops in the bank, 2..32
    parameter int MAX_RETRY = 3    // re-drives after the first failed check, 0..15
) (
    input  logic                     CLK,
    input  logic                     RST,
    input  logic                     REQ_VALID,
    output logic                     REQ_READY,
    input  logic [$clog2(WIDTH)-1:0] REQ_IDX,
    input  logic                     REQ_VAL,
    output logic [WIDTH-1:0]         S,
    output logic [WIDTH-1:0]         R,
    input  logic [WIDTH-1:0]         Q_FB,
    output logic                     DONE,
    output logic                     ERR,
    output logic [3:0]               RETRIES
);

    localparam int         IDX_W       = $clog2(WIDTH);
    localparam logic [3:0] RETRY_LIMIT = 4'(MAX_RETRY);

    // Four states in a 2-bit code: every encoding is a legal state.
    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        DRIVE = 2'b01,
        CHECK = 2'b10,
        RESP  = 2'b11
    } state_t;

    state_t           state;
    state_t           state_nxt;

    // Request captured on accept; REQ_IDX / REQ_VAL are ignored afterwards.
    logic [IDX_W-1:0] idx_q;
    logic             val_q;

    // Re-drives performed so far for the request in flight.
    logic [3:0]       attempt_q;
    logic [3:0]       attempt_nxt;

    logic             accept;
    logic             idx_ok;
    logic             req_bit;
    logic             cur_bit;
    logic             resp_err_nxt;
    logic [3:0]       retries_nxt;
    logic [IDX_W-1:0] drive_idx;
    logic             drive_val;
    logic [WIDTH-1:0] drive_mask;

    assign REQ_READY = (state == IDLE);
    assign accept    = REQ_VALID && REQ_READY;

    // The index field can encode values past the bank when WIDTH is not a
    // power of two; those requests are rejected without touching S/R.
    assign idx_ok    = 32'(REQ_IDX) < 32'(WIDTH);

    // Readback of the requested bit at accept time, and of the latched target
    // bit while checking.
    assign req_bit   = Q_FB[REQ_IDX];
    assign cur_bit   = Q_FB[idx_q];

    // One-hot select of the bit about to be driven. On the accept edge the
    // target comes straight from the request, since idx_q is not loaded yet.
    assign drive_mask = {{(WIDTH-1){1'b0}}, 1'b1} << drive_idx;

    // -------------------------------------------------------------------------
    // Next-state and response decode
    // -------------------------------------------------------------------------
    always_comb begin
        // NOTE: every signal gets a value before the case statement, so no
        // path through the block leaves one unassigned and no latch is inferred.
        state_nxt    = state;
        attempt_nxt  = attempt_q;
        resp_err_nxt = 1'b0;
        retries_nxt  = attempt_q;
        drive_idx    = idx_q;
        drive_val    = val_q;

        case (state)
            IDLE: begin
                if (accept) begin
                    drive_idx   = REQ_IDX;
                    drive_val   = REQ_VAL;
                    attempt_nxt = 4'd0;
                    retries_nxt = 4'd0;
                    if (!idx_ok) begin
                        state_nxt    = RESP;
                        resp_err_nxt = 1'b1;
                    end else if (req_bit == REQ_VAL) begin
                        // Already holds the requested value: nothing to drive.
                        state_nxt = RESP;
                    end else begin
                        state_nxt = DRIVE;
                    end
                end
            end

            DRIVE: state_nxt = CHECK;

            CHECK: begin
                if (cur_bit == val_q) begin
                    state_nxt = RESP;
                end else if (attempt_q < RETRY_LIMIT) begin
                    attempt_nxt = attempt_q + 4'd1;
                    state_nxt   = DRIVE;
                end else begin
                    state_nxt    = RESP;
                    resp_err_nxt = 1'b1;
                end
            end

            RESP: state_nxt = IDLE;

            default: state_nxt = IDLE;
        endcase
    end

    // -------------------------------------------------------------------------
    // State, request capture and registered outputs
    //
    // S, R, DONE, ERR and RETRIES are loaded from the next-state decode, so
    // they are valid during the cycle the FSM spends in DRIVE / RESP.
    // S and R come from one mask gated by opposite senses of drive_val, so no
    // bit can ever see both set and reset at once.
    // -------------------------------------------------------------------------
    always_ff @(posedge CLK) begin
        // NOTE: state is updated with non-blocking assignments so that every
        // register samples values from before the edge, in any order.
        if (RST) begin
            state     <= IDLE;
            idx_q     <= '0;
            val_q     <= 1'b0;
            attempt_q <= 4'd0;
            S         <= '0;
            R         <= '0;
            DONE      <= 1'b0;
            ERR       <= 1'b0;
            RETRIES   <= 4'd0;
        end else begin
            state     <= state_nxt;
            attempt_q <= attempt_nxt;

            if (accept) begin
                idx_q <= REQ_IDX;
                val_q <= REQ_VAL;
            end

            if (state_nxt == DRIVE) begin
                S <= drive_val ? drive_mask : '0;
                R <= drive_val ? '0 : drive_mask;
            end else begin
                S <= '0;
                R <= '0;
            end

            DONE <= (state_nxt == RESP) && !resp_err_nxt;
            ERR  <= (state_nxt == RESP) &&  resp_err_nxt;

            if (state_nxt == RESP) begin
                RETRIES <= retries_nxt;
            end
        end
    end

endmodule
